// File: rtl/cpu_int_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_int_pkg
// Brief    : Shared constants, FSM encoding and vector-address helper for the
//            vectored interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_int_pkg;

    localparam int          c_NUM_INTS_DEF      = 8;
    localparam int          c_ADDR_WIDTH_DEF    = 16;
    localparam int unsigned c_VECTOR_BASE_DEF   = 32'h0000_FF00;
    localparam int unsigned c_VECTOR_STRIDE_DEF = 2;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    // Full-width handler address; callers truncate to their address width.
    function automatic logic [31:0] f_vector_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] idx
    );
        return base + idx * stride;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_int_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : cpu_int_prio_enc
// Brief    : Lowest-index-first priority encoder (bit 0 has highest priority).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_int_prio_enc #(
    parameter int NUM_INTS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_INTS-1:0] req,
    output logic                valid,
    output logic [IDX_W-1:0]    index
);

    // Scan downward so the last hit written is the lowest set index.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_INTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_int_ctrl
// Brief    : Vectored interrupt controller with edge/level requests, masking,
//            fixed priority and req/ack/RETI tracking. Optional nested
//            interrupts via macro CPU_INT_NESTING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int          NUM_INTS      = c_NUM_INTS_DEF,
    parameter int          ADDR_WIDTH    = c_ADDR_WIDTH_DEF,
    parameter int unsigned VECTOR_BASE   = c_VECTOR_BASE_DEF,
    parameter int unsigned VECTOR_STRIDE = c_VECTOR_STRIDE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INTS-1:0]   ints,
    input  logic [NUM_INTS-1:0]   edge_mode,
    input  logic [NUM_INTS-1:0]   mask,
    input  logic                  global_en,
    input  logic                  int_ack,
    input  logic                  int_done,
    output logic                  int_req,
    output logic [ADDR_WIDTH-1:0] int_address,
    output logic [NUM_INTS-1:0]   pending,
    output logic [NUM_INTS-1:0]   in_service
);

    localparam int c_IDX_W = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [NUM_INTS-1:0]   r_ints_prev;
    logic [NUM_INTS-1:0]   r_pending;
    logic [NUM_INTS-1:0]   r_in_service;
    logic [NUM_INTS-1:0]   w_pending_nxt;
    logic [NUM_INTS-1:0]   w_in_service_nxt;
    logic [NUM_INTS-1:0]   w_eligible;
    logic [NUM_INTS-1:0]   w_rise;
    logic [NUM_INTS-1:0]   w_ack_set;
    logic [NUM_INTS-1:0]   w_done_clr;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_win_idx;
    logic                  w_win_valid;
    logic                  w_ack_fire;
    logic                  w_done_fire;
    logic                  w_load;
    logic                  r_int_req;
    logic [ADDR_WIDTH-1:0] r_int_address;

    assign w_eligible = r_pending & mask & ~r_in_service;
    assign w_rise     = ints & ~r_ints_prev;

    cpu_int_prio_enc #(
        .NUM_INTS (NUM_INTS),
        .IDX_W    (c_IDX_W)
    ) u_win_enc (
        .req   (w_eligible),
        .valid (w_win_valid),
        .index (w_win_idx)
    );

`ifdef CPU_INT_NESTING_EN
    logic [c_IDX_W-1:0] w_isr_idx;
    logic               w_isr_valid;
    logic               w_nest_ok;

    cpu_int_prio_enc #(
        .NUM_INTS (NUM_INTS),
        .IDX_W    (c_IDX_W)
    ) u_isr_enc (
        .req   (r_in_service),
        .valid (w_isr_valid),
        .index (w_isr_idx)
    );

    // RETI always retires the highest-priority (lowest index) active handler.
    assign w_done_clr = w_done_fire ? (NUM_INTS'(1) << w_isr_idx) : '0;
    assign w_nest_ok  = global_en & w_win_valid & w_isr_valid & (w_win_idx < w_isr_idx);
`else
    assign w_done_clr = {NUM_INTS{w_done_fire}};
`endif

    // Output/control decode
    always_comb begin
        w_ack_fire  = (r_state == c_ST_REQ) & int_ack;
        w_done_fire = int_done & (|r_in_service);
        w_load      = (r_state != c_ST_REQ) & (w_state_nxt == c_ST_REQ);
        w_ack_set   = w_ack_fire ? (NUM_INTS'(1) << r_idx) : '0;
    end

    // An edge arriving with the ack that consumes it keeps the channel pending.
    for (genvar i = 0; i < NUM_INTS; i++) begin : g_chan
        assign w_pending_nxt[i] = edge_mode[i]
                                ? (w_rise[i] | (r_pending[i] & ~w_ack_set[i]))
                                : (r_in_service[i] ? r_pending[i] : ints[i]);
    end

    assign w_in_service_nxt = (r_in_service & ~w_done_clr) | w_ack_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (global_en && w_win_valid) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = c_ST_SERVICE;
                end else if (!global_en) begin
                    w_state_nxt = (|w_in_service_nxt) ? c_ST_SERVICE : c_ST_IDLE;
                end
            end
            c_ST_SERVICE: begin
                if (w_done_fire) begin
                    w_state_nxt = (|(r_in_service & ~w_done_clr)) ? c_ST_SERVICE : c_ST_IDLE;
                end
`ifdef CPU_INT_NESTING_EN
                else if (w_nest_ok) begin
                    w_state_nxt = c_ST_REQ;
                end
`endif
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ints_prev   <= '0;
            r_pending     <= '0;
            r_in_service  <= '0;
            r_int_req     <= 1'b0;
            r_int_address <= '0;
            r_idx         <= '0;
        end else begin
            r_ints_prev  <= ints;
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
            r_int_req    <= (w_state_nxt == c_ST_REQ);
            if (w_load) begin
                r_idx         <= w_win_idx;
                r_int_address <= ADDR_WIDTH'(f_vector_addr(32'(VECTOR_BASE),
                                                           32'(VECTOR_STRIDE),
                                                           32'(w_win_idx)));
            end
        end
    end

    assign int_req     = r_int_req;
    assign int_address = r_int_address;
    assign pending     = r_pending;
    assign in_service  = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_cpu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_int_ctrl
// Brief    : Table-driven, directed and randomized self-checking bench for
//            cpu_int_ctrl (nesting rows enabled by CPU_INT_NESTING_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ints, edge_mode, mask;
    logic        global_en, int_ack, int_done;
    logic        int_req;
    logic [15:0] int_address;
    logic [7:0]  pending, in_service;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cpu_int_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ints        (ints),
        .edge_mode   (edge_mode),
        .mask        (mask),
        .global_en   (global_en),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .int_req     (int_req),
        .int_address (int_address),
        .pending     (pending),
        .in_service  (in_service)
    );

    typedef struct {
        logic [7:0]  ints, em, mask;
        logic        ge, ack, done;
        logic        req;
        logic [15:0] addr;
        logic [7:0]  pend, isr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic [7:0] i, em, m, input logic ge, ack, done,
                       input logic req, input logic [15:0] addr, input logic [7:0] pend, isr);
        vec_t v;
        v.ints = i; v.em = em; v.mask = m; v.ge = ge; v.ack = ack; v.done = done;
        v.req = req; v.addr = addr; v.pend = pend; v.isr = isr;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [7:0] i, em, m, input logic ge, ack, done);
        ints = i; edge_mode = em; mask = m; global_en = ge; int_ack = ack; int_done = done;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] observed();
        return {int_req, (int_req ? int_address : 16'h0), pending, in_service};
    endfunction

    // ---------------- reference model: channels, pending set, active handlers
    logic [7:0]  m_pend, m_isr, m_prev;
    logic        m_req;
    int          m_ch;
    logic [15:0] m_addr;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] np, ni;
        logic ack, done;
        int w, ls;
        if (reset) begin
            m_pend = 0; m_isr = 0; m_prev = 0; m_req = 0; m_ch = 0; m_addr = 0;
            return;
        end
        ack  = m_req && int_ack;
        done = int_done && (m_isr != 0);
        for (int i = 0; i < 8; i++) begin
            if (edge_mode[i]) np[i] = (ints[i] && !m_prev[i]) || (m_pend[i] && !(ack && m_ch == i));
            else              np[i] = m_isr[i] ? m_pend[i] : ints[i];
        end
        ni = m_isr;
        if (done) begin
`ifdef CPU_INT_NESTING_EN
            ni[lowest(m_isr)] = 1'b0;
`else
            ni = 0;
`endif
        end
        if (ack) ni[m_ch] = 1'b1;
        w  = lowest(m_pend & mask & ~m_isr);
        ls = lowest(m_isr);
        if (m_req) begin
            if (ack || !global_en) m_req = 0;
        end else if (global_en && w >= 0 && !done) begin
`ifdef CPU_INT_NESTING_EN
            if (ls < 0 || w < ls) begin
`else
            if (ls < 0) begin
`endif
                m_req  = 1;
                m_ch   = w;
                m_addr = 16'(32'hFF00 + w * 2);
            end
        end
        m_pend = np; m_isr = ni; m_prev = ints;
    endtask

    initial begin
        reset = 1'b1;
        drive(8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(); step();
        check("reset_state", {int_req, int_address, pending, in_service}, 41'h0);
        reset = 1'b0;

        //   ints   em     mask  ge ack dn   req addr     pend   isr
        add(8'h08, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF06, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF06, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h08);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h00, 8'h08);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
        add(8'h22, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h22, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF02, 8'h22, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h20, 8'h02);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h20, 8'h02);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h20, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF0A, 8'h20, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h20);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
        add(8'h04, 8'hFF, 8'hFB, 1, 0, 0,   0, 16'h0000, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFB, 1, 0, 0,   0, 16'h0000, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFB, 1, 0, 1,   0, 16'h0000, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF04, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 0, 0, 0,   0, 16'h0000, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 0, 0, 0,   0, 16'h0000, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF04, 8'h04, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h04);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
        add(8'h10, 8'hEF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h10, 8'h00);
        add(8'h10, 8'hEF, 8'hFF, 1, 0, 0,   1, 16'hFF08, 8'h10, 8'h00);
        add(8'h10, 8'hEF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h10, 8'h10);
        add(8'h10, 8'hEF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h10, 8'h10);
        add(8'h10, 8'hEF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h10, 8'h00);
        add(8'h10, 8'hEF, 8'hFF, 1, 0, 0,   1, 16'hFF08, 8'h10, 8'h00);
        add(8'h00, 8'hEF, 8'hFF, 1, 0, 0,   1, 16'hFF08, 8'h00, 8'h00);
        add(8'h00, 8'hEF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h10);
        add(8'h00, 8'hEF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
        add(8'h08, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF06, 8'h08, 8'h00);
        add(8'h08, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h08, 8'h08);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h08, 8'h08);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF06, 8'h08, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h08);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
`ifdef CPU_INT_NESTING_EN
        add(8'h40, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h40, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF0C, 8'h40, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h40);
        add(8'h04, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h04, 8'h40);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF04, 8'h04, 8'h40);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h44);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h40);
        add(8'h80, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h80, 8'h40);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   0, 16'h0000, 8'h80, 8'h40);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h80, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 0,   1, 16'hFF0E, 8'h80, 8'h00);
        add(8'h00, 8'hFF, 8'hFF, 1, 1, 0,   0, 16'h0000, 8'h00, 8'h80);
        add(8'h00, 8'hFF, 8'hFF, 1, 0, 1,   0, 16'h0000, 8'h00, 8'h00);
`endif

        foreach (tbl[k]) begin
            drive(tbl[k].ints, tbl[k].em, tbl[k].mask, tbl[k].ge, tbl[k].ack, tbl[k].done);
            step();
            check($sformatf("row%0d", k + 1), observed(),
                  {tbl[k].req, tbl[k].addr, tbl[k].pend, tbl[k].isr});
        end

        // Reset while a request is outstanding
        drive(8'h01, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); step();
        drive(8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); step();
        check("pre_reset_req", observed(), {1'b1, 16'hFF00, 8'h01, 8'h00});
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_mid_req", {int_req, int_address, pending, in_service}, 41'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("no_req_after_reset%0d", c), {int_req, pending}, 9'h0);
        end
        drive(8'h01, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); step();
        drive(8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); step();
        check("req_after_new_edge", observed(), {1'b1, 16'hFF00, 8'h01, 8'h00});
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check("ack_before_reset", observed(), {1'b0, 16'h0, 8'h00, 8'h01});
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_mid_service", {int_req, int_address, pending, in_service}, 41'h0);

        // Randomized traffic against the reference model
        reset = 1'b1;
        drive(8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        @(posedge clk); model_step(); #1;
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            ints      = ints ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) edge_mode = 8'($urandom);
            if ($urandom_range(0, 29) == 0) mask = 8'($urandom) | 8'h81;
            global_en = ($urandom_range(0, 9) != 0);
            int_ack   = ($urandom_range(0, 2) == 0);
            int_done  = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand%0d", c), observed(),
                  {m_req, (m_req ? m_addr : 16'h0), m_pend, m_isr});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
